bp_cfg_tile_loader: RTL and testbench
=====================================

// Module: bp_cfg_tile_loader
// PURPOSE
// - Boot-time configuration sequencer; consumes the selected bp_proc_param_s config.
// - On start, walks every core tile (cc_x_dim_p x cc_y_dim_p) and issues config-register writes over a valid/ready link.
// - Writes per tile: freeze, core id, coord, cce/icache/dcache mode, boot npc. Then unfreezes all tiles. Sits between the testbench/host and the per-tile cfg slaves.
// PARAMETERS
// - cc_x_dim_p        1          core columns; from selected proc config
// - cc_y_dim_p        1          core rows; from selected proc config
// - cfg_addr_width_p  16         config register address width
// - cfg_data_width_p  64         config write data width
// - boot_pc_p         'h8000_0000  value written to npc register
// - Derived: num_tiles_lp = cc_x_dim_p*cc_y_dim_p
// - Derived: tile_id_width_lp = `BSG_SAFE_CLOG2(num_tiles_lp)
// PORTS
// - clk_i        in   1                  clock
// - reset_n_i    in   1                  asynchronous, active-low reset
// - start_i      in   1                  pulse: begin sequence (honoured in IDLE or DONE only)
// - cce_mode_i   in   1                  0=uncached, 1=normal; sampled at start
// - cfg_v_o      out  1                  config write valid
// - cfg_ready_i  in   1                  slave accepts write when cfg_v_o & cfg_ready_i
// - cfg_dst_o    out  tile_id_width_lp   destination tile index (y*cc_x_dim_p + x)
// - cfg_addr_o   out  cfg_addr_width_p   config register address
// - cfg_data_o   out  cfg_data_width_p   write data, zero-extended
// - busy_o       out  1                  high in PROG/UNFREEZE
// - done_o       out  1                  high in DONE
// BEHAVIOUR
// - Reset (async, reset_n_i=0): state=IDLE; tile_cnt=0; reg_idx=0; all outputs 0.
// - FSM: IDLE -start_i-> PROG -last write of last tile-> UNFREEZE -last tile-> DONE -start_i-> PROG.
// - start_i is ignored in PROG/UNFREEZE. cce_mode_i is captured in a register at the accepted start.
// - PROG: for tile t=0..N-1, reg_idx 0..6 in this order:
//   - freeze=1
//   - core_id=t
//   - coord={y,x}, x in [7:0], y in [15:8]
//   - cce_mode=captured cce_mode
//   - icache_mode=captured cce_mode
//   - dcache_mode=captured cce_mode
//   - npc=boot_pc_p
// - UNFREEZE: freeze=0 to tiles 0..N-1 in order.
// - Total writes per sequence = 8*num_tiles_lp.
// - Handshake: cfg_v_o is high in PROG/UNFREEZE.
//   - Advance only on cfg_v_o & cfg_ready_i; one write per cycle max.
//   - dst/addr/data are stable while cfg_v_o & ~cfg_ready_i.
// - First cfg_v_o is asserted the cycle after start_i is sampled. Back-to-back writes with ready held high.
// - Counters: reg_idx wraps 6->0 and increments tile_cnt.
//   - x/y are tracked with separate counters; x wraps at cc_x_dim_p-1.
//   - tile_cnt wraps to 0 entering UNFREEZE and entering DONE.
// - done_o goes high the cycle after the last unfreeze handshake. It stays high until a new start_i; done_o drops the cycle after start_i.
// - Reset mid-sequence: immediate return to IDLE with cfg_v_o=0; no partial state retained.
// - num_tiles_lp=1: cfg_dst_o is 1 bit and always 0.
// STRUCTURE
// - Shared package bp_common_cfg_link_pkg:
//   - bp_cfg_reg_e address enum: freeze=0x0001, core_id=0x0002, coord=0x0003, cce_mode=0x0004, icache_mode=0x0005, dcache_mode=0x0006, npc=0x0007
//   - bp_cfg_loader_state_e FSM enum
//   - cce_mode encodings
// - No sub-module; one FSM plus address/data mux. bsg_counter_clear_up is permitted for tile_cnt.
// TESTING
// - 1x1, ready=1, cce_mode_i=1, start:
//   - 8 writes on consecutive cycles
//   - addrs 1,2,3,4,5,6,7,1
//   - data 1,0,0,1,1,1,8000_0000,0
//   - done_o the next cycle
// - 2x2, ready=1:
//   - 32 writes
//   - tile 3 coord data = 0x0101
//   - unfreeze dst order 0,1,2,3
//   - busy_o high for exactly 32 cycles
// - Backpressure: ready low 5 cycles on the 3rd write -> dst/addr/data held constant; no write skipped or duplicated.
// - Reset pulse at write 10 of 2x2 -> cfg_v_o=0 same cycle; after restart the sequence begins again at tile 0 freeze.
// - start_i pulsed mid-PROG -> ignored; write count still 8*N.
// - Restart from DONE with cce_mode_i=0 -> mode writes carry 0.

Source files
------------

// File: rtl/bp_common_cfg_link_pkg.sv
// bp_common_cfg_link_pkg: config-link register map, loader FSM states and cce mode encodings
package bp_common_cfg_link_pkg;
  typedef enum logic [15:0] {
    e_cfg_freeze      = 16'h0001,
    e_cfg_core_id     = 16'h0002,
    e_cfg_coord       = 16'h0003,
    e_cfg_cce_mode    = 16'h0004,
    e_cfg_icache_mode = 16'h0005,
    e_cfg_dcache_mode = 16'h0006,
    e_cfg_npc         = 16'h0007
  } bp_cfg_reg_e;
  typedef enum logic [1:0] {
    e_ld_idle,
    e_ld_prog,
    e_ld_unfreeze,
    e_ld_done
  } bp_cfg_loader_state_e;
  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;
  localparam int cfg_regs_per_tile_lp = 7;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  // per-tile registers are walked in address order starting at freeze
  function automatic bp_cfg_reg_e reg_of_idx(input logic [2:0] idx);
    return bp_cfg_reg_e'(16'(idx) + 16'd1);
  endfunction
endpackage

// File: rtl/bp_cfg_tile_loader_if.sv
// bp_cfg_tile_loader_if: valid/ready config write link between loader and per-tile cfg slaves
interface bp_cfg_tile_loader_if #(
  parameter int dst_width_p  = 1,
  parameter int addr_width_p = 16,
  parameter int data_width_p = 64
);
  logic                    v;
  logic                    ready;
  logic [dst_width_p-1:0]  dst;
  logic [addr_width_p-1:0] addr;
  logic [data_width_p-1:0] data;
  modport master (output v, dst, addr, data, input ready);
  modport slave  (input v, dst, addr, data, output ready);
endinterface

// File: rtl/bp_cfg_tile_loader.sv
// bp_cfg_tile_loader: boot-time sequencer writing per-tile config registers, then unfreezing all tiles
module bp_cfg_tile_loader
  import bp_common_cfg_link_pkg::*;
#(
  parameter int cc_x_dim_p       = 1,
  parameter int cc_y_dim_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter logic [cfg_data_width_p-1:0] boot_pc_p = 'h8000_0000
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   cce_mode_i,
  bp_cfg_tile_loader_if.master   cfg,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int num_tiles_lp     = cc_x_dim_p * cc_y_dim_p;
  localparam int tile_id_width_lp = safe_clog2(num_tiles_lp);
  localparam int x_width_lp       = safe_clog2(cc_x_dim_p);
  localparam int y_width_lp       = safe_clog2(cc_y_dim_p);
  bp_cfg_loader_state_e        state_r, state_n;
  logic [tile_id_width_lp-1:0] tile_r, tile_n;
  logic [x_width_lp-1:0]       x_r, x_n;
  logic [y_width_lp-1:0]       y_r, y_n;
  logic [2:0]                  idx_r, idx_n;
  bp_cce_mode_e                mode_r, mode_n;
  logic                        fire, last_tile, last_reg, last_x;
  bp_cfg_reg_e                 reg_addr;
  logic [15:0]                 coord;
  logic [cfg_data_width_p-1:0] prog_data;
  assign fire      = cfg.v & cfg.ready;
  assign last_tile = tile_r == tile_id_width_lp'(num_tiles_lp - 1);
  assign last_reg  = idx_r == 3'(cfg_regs_per_tile_lp - 1);
  assign last_x    = x_r == x_width_lp'(cc_x_dim_p - 1);
  assign reg_addr  = reg_of_idx(idx_r);
  assign coord     = {8'(y_r), 8'(x_r)};
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= e_ld_idle;
      tile_r  <= '0;
      x_r     <= '0;
      y_r     <= '0;
      idx_r   <= '0;
      mode_r  <= e_cce_mode_uncached;
    end else begin
      state_r <= state_n;
      tile_r  <= tile_n;
      x_r     <= x_n;
      y_r     <= y_n;
      idx_r   <= idx_n;
      mode_r  <= mode_n;
    end
  always_comb begin
    state_n = state_r;
    tile_n  = tile_r;
    x_n     = x_r;
    y_n     = y_r;
    idx_n   = idx_r;
    mode_n  = mode_r;
    case (state_r)
      e_ld_idle, e_ld_done:
        if (start_i) begin
          state_n = e_ld_prog;
          mode_n  = bp_cce_mode_e'(cce_mode_i);
          tile_n  = '0;
          x_n     = '0;
          y_n     = '0;
          idx_n   = '0;
        end
      e_ld_prog:
        if (fire) begin
          idx_n = last_reg ? 3'd0 : idx_r + 3'd1;
          if (last_reg) begin
            tile_n  = last_tile ? '0 : tile_r + 1'b1;
            x_n     = (last_tile | last_x) ? '0 : x_r + 1'b1;
            y_n     = last_tile ? '0 : last_x ? y_r + 1'b1 : y_r;
            state_n = last_tile ? e_ld_unfreeze : e_ld_prog;
          end
        end
      e_ld_unfreeze:
        if (fire) begin
          tile_n  = last_tile ? '0 : tile_r + 1'b1;
          state_n = last_tile ? e_ld_done : e_ld_unfreeze;
        end
      default: state_n = e_ld_idle;
    endcase
  end
  // the three mode registers all take the mode captured at start
  assign prog_data = (reg_addr == e_cfg_freeze)  ? cfg_data_width_p'(1)
                   : (reg_addr == e_cfg_core_id) ? cfg_data_width_p'(tile_r)
                   : (reg_addr == e_cfg_coord)   ? cfg_data_width_p'(coord)
                   : (reg_addr == e_cfg_npc)     ? boot_pc_p
                   : cfg_data_width_p'(mode_r);
  assign busy_o   = (state_r == e_ld_prog) | (state_r == e_ld_unfreeze);
  assign done_o   = state_r == e_ld_done;
  assign cfg.v    = busy_o;
  assign cfg.dst  = tile_r;
  assign cfg.addr = (state_r == e_ld_prog)     ? cfg_addr_width_p'(reg_addr)
                  : (state_r == e_ld_unfreeze) ? cfg_addr_width_p'(e_cfg_freeze)
                  : '0;
  assign cfg.data = (state_r == e_ld_prog) ? prog_data : '0;
endmodule

// File: tb/tb_bp_cfg_tile_loader.sv
// tb_bp_cfg_tile_loader: 1x1 and 2x2 loaders checked against a vector table and a write scoreboard
module tb_bp_cfg_tile_loader;
  import bp_common_cfg_link_pkg::*;
  typedef struct packed {
    logic [7:0]  dst;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } vec_t;
  logic clk = 0, rst_n = 0, start_a = 0, start_b = 0, mode_a = 1, mode_b = 1;
  logic busy_a, done_a, busy_b, done_b;
  int   n_vec = 0, n_bad = 0, wr_a = 0, wr_b = 0;
  wr_t  q_a[$], q_b[$];
  wr_t  cur_b, held_b;
  logic stall_b = 0;
  vec_t tbl[8];
  always #5 clk = ~clk;
  bp_cfg_tile_loader_if #(.dst_width_p(1)) la();
  bp_cfg_tile_loader_if #(.dst_width_p(2)) lb();
  bp_cfg_tile_loader #(.cc_x_dim_p(1), .cc_y_dim_p(1)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a), .cce_mode_i(mode_a),
    .cfg(la.master), .busy_o(busy_a), .done_o(done_a));
  bp_cfg_tile_loader #(.cc_x_dim_p(2), .cc_y_dim_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .cce_mode_i(mode_b),
    .cfg(lb.master), .busy_o(busy_b), .done_o(done_b));
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_seq(input bit to_b, input int nx, input int ny, input logic m);
    wr_t e;
    for (int t = 0; t < nx * ny; t++)
      for (int r = 0; r < 7; r++) begin
        e.dst  = 8'(t);
        e.addr = 16'(r + 1);
        case (r)
          0: e.data = 64'd1;
          1: e.data = 64'(t);
          2: e.data = 64'(((t / nx) << 8) | (t % nx));
          6: e.data = 64'h8000_0000;
          default: e.data = 64'(m);
        endcase
        if (to_b) q_b.push_back(e); else q_a.push_back(e);
      end
    for (int t = 0; t < nx * ny; t++) begin
      e = '{dst: 8'(t), addr: 16'h1, data: 64'h0};
      if (to_b) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask
  task automatic pulse(input bit to_b);
    @(posedge clk); #1;
    if (to_b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
  endtask
  task automatic wait_done_b(input string name, output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!done_b && n < 400) begin
      @(negedge clk);
      if (busy_b) busy_cycles++;
      n++;
    end
    check({name, "_done"}, 96'(done_b), 96'd1);
    check({name, "_writes"}, 96'(wr_b), 96'd32);
    check({name, "_queue_empty"}, 96'(q_b.size()), 96'd0);
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (la.v && la.ready) begin
        wr_a++;
        if (q_a.size() == 0) check("a_extra_write", 96'(q_a.size()), 96'd1);
        else check("a_write", 96'({8'(la.dst), la.addr, la.data}), 96'(q_a.pop_front()));
      end
      cur_b = '{dst: 8'(lb.dst), addr: lb.addr, data: lb.data};
      if (lb.v && lb.ready) begin
        wr_b++;
        if (lb.addr == 16'h3 && lb.dst == 2'd3) check("b_tile3_coord", 96'(lb.data), 96'h101);
        if (q_b.size() == 0) check("b_extra_write", 96'(q_b.size()), 96'd1);
        else check("b_write", 96'(cur_b), 96'(q_b.pop_front()));
      end
      if (lb.v && !lb.ready) begin
        if (stall_b) check("b_hold_stable", 96'(cur_b), 96'(held_b));
        held_b  = cur_b;
        stall_b = 1;
      end else stall_b = 0;
    end
  end
  initial begin
    int bc, n, held;
    tbl[0] = '{16'h1, 64'h1};
    tbl[1] = '{16'h2, 64'h0};
    tbl[2] = '{16'h3, 64'h0};
    tbl[3] = '{16'h4, 64'h1};
    tbl[4] = '{16'h5, 64'h1};
    tbl[5] = '{16'h6, 64'h1};
    tbl[6] = '{16'h7, 64'h8000_0000};
    tbl[7] = '{16'h1, 64'h0};
    la.ready = 1;
    lb.ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", 96'({la.v, busy_a, done_a, la.dst, la.addr, la.data}), 96'd0);
    check("rst_b", 96'({lb.v, busy_b, done_b, lb.dst, lb.addr, lb.data}), 96'd0);
    rst_n = 1;
    push_seq(0, 1, 1, 1);
    pulse(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("a_vec%0d", i), 96'({la.v, la.addr, la.data}), 96'({1'b1, tbl[i].addr, tbl[i].data}));
    end
    @(negedge clk);
    check("a_done_next", 96'({done_a, la.v}), 96'b10);
    check("a_queue_empty", 96'(q_a.size()), 96'd0);
    mode_a = 0;
    push_seq(0, 1, 1, 0);
    pulse(0);
    check("a_done_drops", 96'({done_a, la.v}), 96'b01);
    n = 0;
    while (!done_a && n < 50) begin @(negedge clk); n++; end
    check("a_mode0_done", 96'(done_a), 96'd1);
    check("a_mode0_queue_empty", 96'(q_a.size()), 96'd0);
    push_seq(1, 2, 2, 1);
    wr_b = 0;
    pulse(1);
    wait_done_b("b_full", bc);
    check("b_busy_cycles", 96'(bc), 96'd32);
    push_seq(1, 2, 2, 1);
    wr_b = 0;
    pulse(1);
    n = 0;
    held = 0;
    while (!done_b && n < 400) begin
      @(posedge clk); #1;
      if (wr_b == 2 && held < 5) begin lb.ready = 0; held++; end
      else lb.ready = 1;
      n++;
    end
    lb.ready = 1;
    wait_done_b("b_backpressure", bc);
    check("b_stall_cycles", 96'(held), 96'd5);
    push_seq(1, 2, 2, 1);
    wr_b = 0;
    pulse(1);
    n = 0;
    while (wr_b < 10 && n < 100) begin @(posedge clk); #1; n++; end
    check("b_reached_write10", 96'(wr_b), 96'd10);
    rst_n = 0;
    #1;
    check("b_mid_reset", 96'({lb.v, busy_b, done_b, lb.dst, lb.addr, lb.data}), 96'd0);
    q_b.delete();
    @(posedge clk); #1;
    rst_n = 1;
    push_seq(1, 2, 2, 1);
    wr_b = 0;
    pulse(1);
    check("b_restart_first", 96'({lb.v, lb.dst, lb.addr, lb.data}), 96'({1'b1, 2'd0, 16'h1, 64'h1}));
    wait_done_b("b_after_reset", bc);
    push_seq(1, 2, 2, 1);
    wr_b = 0;
    pulse(1);
    repeat (5) @(posedge clk);
    #1;
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    wait_done_b("b_ignore_start", bc);
    mode_b = 0;
    push_seq(1, 2, 2, 0);
    wr_b = 0;
    check("b_done_before_restart", 96'(done_b), 96'd1);
    pulse(1);
    check("b_done_drops", 96'({done_b, lb.v}), 96'b01);
    wait_done_b("b_mode0", bc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
